uart_tx: RTL and testbench

UART transmitter: serialises bytes as 8N1 (optionally 8N2) frames on a single line, LSB first, at CLOCKS_PER_BAUD clocks per bit. It is the transmit-side counterpart of the design's UART receiver and uses the same baud parameterisation, so a tx/rx pair built with the same parameter loops back cleanly. Bytes arrive on a valid/ready handshake into a one-entry holding register, so the next byte can be queued during a frame and sent with no idle gap.

---
 rtl/uart_tx_pkg.sv | 15 +
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_baud_timer.sv | 30 +++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: default baud divisor,
// FSM state encoding and frame constants.
package uart_tx_pkg;

  localparam int CPB_DEFAULT = 6;
  localparam int DATA_BITS   = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_START = 2'd1;
  localparam state_t S_BITS  = 2'd2;
  localparam state_t S_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_if.sv
// Byte valid/ready handshake into the UART
// transmitter holding register.
interface uart_tx_if;

  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o
  );

endinterface

// File: rtl/uart_baud_timer.sv
// Bit-period down-counter: reload on load, then
// count to zero and hold there until reloaded.
module uart_baud_timer #(
  parameter int CLOCKS_PER_BAUD = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  output logic done
);

  localparam int W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [W-1:0] TOP =
    W'(CLOCKS_PER_BAUD - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TOP;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, 1 or 2
// stop bits, one-entry holding register for gapless frames.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = CPB_DEFAULT,
  parameter int STOP_BITS       = 1
) (
  input  logic     clock,
  input  logic     reset_n,
  uart_tx_if.slave bus,
  output logic     tx_o,
  output logic     busy_o
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t     state, state_n;
  logic [2:0] bit_idx, bit_n;
  logic       stop_idx, stop_n;
  logic [7:0] shift, shift_n;
  logic [7:0] hold, hold_n;
  logic       hold_full, full_n;
  logic       ready_q;
  logic       tx_q, tx_n;
  logic       load, done, accept;

  uart_baud_timer #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_baud (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .done    (done)
  );

  assign accept = bus.valid_i && ready_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ready_q   <= 1'b1;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_n;
      stop_idx  <= stop_n;
      shift     <= shift_n;
      hold      <= hold_n;
      hold_full <= full_n;
      ready_q   <= !full_n;
      tx_q      <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    shift_n = shift;
    hold_n  = hold;
    full_n  = hold_full;
    load    = 1'b0;
    // ready_q low while full, so accept never meets a drain
    if (accept) begin
      hold_n = bus.data_i;
      full_n = 1'b1;
    end
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          shift_n = hold;
          full_n  = 1'b0;
          state_n = S_START;
          load    = 1'b1;
        end
      end
      S_START: begin
        if (done) begin
          state_n = S_BITS;
          bit_n   = '0;
          load    = 1'b1;
        end
      end
      S_BITS: begin
        if (done) begin
          shift_n = {1'b0, shift[7:1]};
          load    = 1'b1;
          if (bit_idx == LAST_BIT) begin
            state_n = S_STOP;
            stop_n  = 1'b0;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (done) begin
          load = 1'b1;
          if (stop_idx != LAST_STOP) begin
            stop_n = 1'b1;
          end else if (hold_full) begin
            shift_n = hold;
            full_n  = 1'b0;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // line level is registered from the next state
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_BITS:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign bus.ready_o = ready_q;
  assign tx_o        = tx_q;
  assign busy_o      = (state != S_IDLE) || hold_full;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: random and directed bytes, line
// waveform checked against an ideal 8N1/8N2 frame model.
module tb_uart_tx;

  localparam int CPB = 6;
  localparam int NONE = -100000;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  logic tx1, tx2, busy1, busy2;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];
  int acc_q1[$];
  int acc_q2[$];
  int fall_q1[$];
  int fall_q2[$];

  uart_tx_if bus1();
  uart_tx_if bus2();

  uart_tx #(
    .CLOCKS_PER_BAUD(CPB),
    .STOP_BITS(1)
  ) dut1 (
    .clock   (clock),
    .reset_n (rst_n),
    .bus     (bus1),
    .tx_o    (tx1),
    .busy_o  (busy1)
  );

  uart_tx #(
    .CLOCKS_PER_BAUD(CPB),
    .STOP_BITS(2)
  ) dut2 (
    .clock   (clock),
    .reset_n (rst_n),
    .bus     (bus2),
    .tx_o    (tx2),
    .busy_o  (busy2)
  );

  always #5 clock = ~clock;

  // scoreboard push: every handshake queues its byte
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus1.valid_i && bus1.ready_o) begin
        exp_q1.push_back(bus1.data_i);
        acc_q1.push_back(cyc);
      end
      if (bus2.valid_i && bus2.ready_o) begin
        exp_q2.push_back(bus2.data_i);
        acc_q2.push_back(cyc);
      end
    end
  end

  task automatic chk(input string nm,
                     input longint act,
                     input longint want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, want);
    end
  endtask

  function automatic logic line(input int k);
    return (k == 0) ? tx1 : tx2;
  endfunction

  function automatic logic rdy(input int k);
    return (k == 0) ? bus1.ready_o : bus2.ready_o;
  endfunction

  function automatic logic bsy(input int k);
    return (k == 0) ? busy1 : busy2;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q1.size() : exp_q2.size();
  endfunction

  task automatic pop(input int k,
                     output logic [7:0] b,
                     output int a);
    if (k == 0) begin
      b = exp_q1.pop_front();
      a = acc_q1.pop_front();
    end else begin
      b = exp_q2.pop_front();
      a = acc_q2.pop_front();
    end
  endtask

  // call at a negedge; returns at the negedge after the accept edge
  task automatic send(input int k,
                      input logic [7:0] b,
                      output int a);
    int t;
    t = 0;
    if (k == 0) begin
      bus1.data_i  = b;
      bus1.valid_i = 1'b1;
    end else begin
      bus2.data_i  = b;
      bus2.valid_i = 1'b1;
    end
    while (rdy(k) !== 1'b1 && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t >= 300) begin
      chk("send_timeout", t, 0);
      a = -1;
    end else begin
      @(posedge clock);
      @(negedge clock);
      a = cyc - 1;
    end
    if (k == 0) bus1.valid_i = 1'b0;
    else        bus2.valid_i = 1'b0;
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while ((qsize(k) != 0 || bsy(k) !== 1'b0)
           && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk("drain", t < 3000, 1);
    repeat (2) @(negedge clock);
  endtask

  // monitor: ideal frame = start, 8 data LSB first, S stops
  task automatic mon(input int k, input int S);
    int f, a, pe, n, errs, idx, want_st;
    logic [7:0] b, got;
    logic v, want, abort;
    pe = NONE;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        pe = NONE;
        continue;
      end
      if (line(k) !== 1'b0) continue;
      f = cyc - 1;
      if (qsize(k) == 0) begin
        chk("unexpected_frame", f, -1);
        b = 8'h00;
        a = f - 1;
      end else begin
        pop(k, b, a);
      end
      n     = (9 + S) * CPB;
      errs  = 0;
      got   = 8'h00;
      abort = 1'b0;
      for (int c = 0; c < n; c++) begin
        if (c > 0) @(negedge clock);
        if (!rst_n) begin
          abort = 1'b1;
          break;
        end
        v   = line(k);
        idx = c / CPB;
        if (idx == 0)      want = 1'b0;
        else if (idx <= 8) want = b[idx-1];
        else               want = 1'b1;
        if (v !== want) errs++;
        if (idx >= 1 && idx <= 8 && c % CPB == CPB / 2)
          got[idx-1] = v;
      end
      if (abort) begin
        pe = NONE;
        continue;
      end
      want_st = (a + 1 > pe + 1) ? a + 1 : pe + 1;
      chk("start_cycle", f, want_st);
      chk("wave_errs", errs, 0);
      chk("rx_byte", got, b);
      if (k == 0) fall_q1.push_back(f);
      else        fall_q2.push_back(f);
      pe = f + n - 1;
    end
  endtask

  initial mon(0, 1);
  initial mon(1, 2);

  initial begin
    int a, a1, a2, a3, lows, gap;
    logic [7:0] rb;
    logic [7:0] lb[4];
    bus1.valid_i = 1'b0;
    bus1.data_i  = 8'h00;
    bus2.valid_i = 1'b0;
    bus2.data_i  = 8'h00;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx1", tx1, 1);
    chk("rst_ready1", bus1.ready_o, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_tx2", tx2, 1);
    chk("rst_ready2", bus2.ready_o, 1);
    chk("rst_busy2", busy2, 0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;

    lows = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx1 !== 1'b1) lows++;
    end
    chk("idle_line", lows, 0);

    send(0, 8'h55, a);
    chk("ready_cycle_a", bus1.ready_o, 0);
    @(negedge clock);
    chk("ready_cycle_a1", bus1.ready_o, 1);
    repeat (59) @(negedge clock);
    chk("busy_last_stop", busy1, 1);
    @(negedge clock);
    chk("busy_after", busy1, 0);
    drain(0);

    send(0, 8'hA5, a1);
    send(0, 8'h3C, a2);
    chk("b2b_accept", a2 - a1, 2);
    send(0, 8'h99, a3);
    chk("third_wait", a3 - a1, 62);
    drain(0);
    chk("b2b_gap1",
        fall_q1[$] - fall_q1[$-1], 60);

    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h80;
    lb[3] = 8'h01;
    foreach (lb[i]) send(0, lb[i], a);
    drain(0);

    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom);
      send(0, rb, a);
      gap = ($urandom_range(0, 1) == 0)
            ? 0 : int'($urandom_range(1, 80));
      repeat (gap) @(negedge clock);
    end
    drain(0);

    send(1, 8'hC3, a);
    drain(1);
    send(1, 8'h12, a);
    send(1, 8'h34, a);
    drain(1);
    chk("b2b_gap2",
        fall_q2[$] - fall_q2[$-1], 66);

    send(0, 8'h0F, a1);
    send(0, 8'hF0, a2);
    repeat (25) @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx1, 1);
    chk("mid_rst_ready", bus1.ready_o, 1);
    chk("mid_rst_busy", busy1, 0);
    exp_q1.delete();
    acc_q1.delete();
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    lows = 0;
    repeat (150) begin
      @(negedge clock);
      if (tx1 !== 1'b1) lows++;
    end
    chk("post_rst_quiet", lows, 0);

    send(0, 8'h5A, a);
    drain(0);

    chk("q1_empty", exp_q1.size(), 0);
    chk("q2_empty", exp_q2.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
